// File: rtl/calc_pkg.sv
// Shared constants, opcodes and state encoding for the calculator op sequencer.
package calc_pkg;

    localparam int DATA_W   = 16;
    localparam int RES_W    = 2 * DATA_W;
    localparam int MUL_ITER = 16;
    localparam int CNT_W    = 5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_adder16.sv
// 16-bit ripple-carry adder; each bit is a full-adder cell.
module seq_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] carry;

    assign carry[0] = cin;

    // Full-adder cell per bit, carry rippling upward.
    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[16];

endmodule

// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL controller around one shared 16-bit adder.
// Optional macro CALC_SEQ_ERR_EN: reserved opcode yields Q=0 with err=1;
// otherwise the reserved opcode behaves as ADD and err stays low.
module calc_op_sequencer #(
    parameter int DATA_W = calc_pkg::DATA_W,
    parameter int RES_W  = calc_pkg::RES_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [RES_W-1:0]  Q
);
    import calc_pkg::*;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITER);
    localparam logic [CNT_W-1:0] ONE_LAST = CNT_W'(1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0]    p_q, p_d, q_q, q_d;
    logic                err_q, err_d;

    logic                is_sub, is_mul, is_rsv;
    logic                wb;
    logic [DATA_W-1:0]   add_a, add_b, add_sum;
    logic                add_cin, add_cout;

    // Opcode decode of the captured operation.
    always_comb begin
        is_sub = 1'b0;
        is_mul = 1'b0;
        is_rsv = 1'b0;
        case (op_q)
            OP_ADD: ;
            OP_SUB: is_sub = 1'b1;
            OP_MUL: is_mul = 1'b1;
            OP_RSV: begin
`ifdef CALC_SEQ_ERR_EN
                is_rsv = 1'b1;
`else
                is_rsv = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Writeback cycle: all iterations finished, result moves into Q next edge.
    assign wb = (cnt_q == (is_mul ? MUL_LAST : ONE_LAST));

    // Shared adder operand steering.
    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_cin = 1'b0;
        if (is_mul) begin
            add_a = p_q[RES_W-1:DATA_W];
            add_b = p_q[0] ? a_q : '0;
        end else if (is_sub) begin
            add_b   = ~b_q;
            add_cin = 1'b1;
        end
    end

    seq_adder16 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        err_d   = err_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                done = (state_q == ST_DONE);
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    p_d     = {{(RES_W-DATA_W){1'b0}}, B};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (!wb) begin
                    busy  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (is_mul)
                        p_d = {add_cout, add_sum, p_q[DATA_W-1:1]};
                    else
                        p_d = {{(RES_W-DATA_W-1){1'b0}}, add_cout ^ is_sub, add_sum};
                end else begin
                    // start is not sampled here; the op is still retiring.
                    q_d     = is_rsv ? '0 : p_q;
                    err_d   = is_rsv;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    assign Q   = q_q;
    assign err = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer (scoreboard queue of expected results).
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] A, B;
    logic        busy, done, err;
    logic [31:0] Q;

    typedef struct {
        logic [31:0] q;
        logic        err;
        int          lat;
        int          busy_cycles;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] prev_q = '0;

    calc_op_sequencer #(.DATA_W(16), .RES_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .Q     (Q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_q(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        case (o)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; return {15'b0, s}; end
            2'b01: begin s = {1'b0, a} - {1'b0, b}; return {15'b0, (a < b), s[15:0]}; end
            2'b10: return {16'b0, a} * {16'b0, b};
            default: begin
`ifdef CALC_SEQ_ERR_EN
                return 32'h0;
`else
                s = {1'b0, a} + {1'b0, b};
                return {15'b0, s};
`endif
            end
        endcase
    endfunction

    function automatic logic ref_err(input logic [1:0] o);
`ifdef CALC_SEQ_ERR_EN
        return (o == 2'b11);
`else
        return (o == 2'b11) && 1'b0;
`endif
    endfunction

    // Issue one op (called #1 after an edge), track it to done and score it.
    // inj > 0 drives an extra ADD start sampled at that edge, which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input int inj);
        exp_t e;
        exp_t got;
        int   n;
        int   bc;
        e.q           = ref_q(o, a, b);
        e.err         = ref_err(o);
        e.lat         = (o == 2'b10) ? 17 : 2;
        e.busy_cycles = (o == 2'b10) ? 16 : 1;
        sb.push_back(e);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        n  = 0;
        bc = busy ? 1 : 0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("q_held_edge0", Q, prev_q);
        check("err_cleared_on_accept", {31'b0, err}, 32'd0);
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
            if (n == 1) check("q_held_edge1", Q, prev_q);
            if (inj > 0 && n == inj - 1) begin
                start = 1'b1; op = 2'b00; A = 16'h0001; B = 16'h0001;
            end
            if (inj > 0 && n == inj) begin
                start = 1'b0;
                check("ignored_start_q", Q, prev_q);
                check("ignored_start_busy", {31'b0, busy}, 32'd1);
            end
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("done_seen", {31'b0, done}, 32'd1);
            check("result_q", Q, got.q);
            check("result_err", {31'b0, err}, {31'b0, got.err});
            check("latency", n, got.lat);
            check("busy_cycles", bc, got.busy_cycles);
            check("busy_low_in_done", {31'b0, busy}, 32'd0);
            prev_q = got.q;
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("no_spurious_done", {31'b0, done}, 32'd0);
        end
    endtask

    initial begin
        int stray;
        rst = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        #23;
        check("reset_q", Q, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'b00, 16'hFFFF, 16'h0001, 0);
        run_op(2'b01, 16'h0005, 16'h0007, 0);   // back-to-back from DONE
        run_op(2'b01, 16'h0007, 16'h0005, 0);
        idle(3);
        run_op(2'b10, 16'hFFFF, 16'hFFFF, 0);
        run_op(2'b10, 16'h1234, 16'h0000, 0);
        idle(2);
        run_op(2'b10, 16'h0003, 16'h0004, 5);   // ADD start at edge 5 ignored
        check("no_extra_result", sb.size(), 32'd0);
        run_op(2'b00, 16'h00AA, 16'h0055, 0);   // accepted in the DONE cycle

        // Asynchronous reset in the middle of a MUL.
        start = 1'b1; op = 2'b10; A = 16'h0005; B = 16'h0007;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin @(posedge clk); end
        #3 rst = 1'b1;
        #1;
        check("abort_q", Q, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        prev_q = '0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        check("no_done_after_abort", stray, 32'd0);
        run_op(2'b00, 16'h0002, 16'h0003, 0);

        run_op(2'b11, 16'h0001, 16'h0002, 0);
        run_op(2'b00, 16'h000A, 16'h0014, 0);   // clears err when enabled

        for (int i = 0; i < 4; i++) begin
            logic [1:0] ro;
            ro = 2'($urandom_range(0, 2));
            run_op(ro, 16'($urandom), 16'($urandom), 0);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Multi-cycle operation controller for the Simple Calculator datapath.
- Takes one opcode and two 16-bit operands, then drives a single shared 16-bit ripple adder to produce ADD, SUB or unsigned MUL results.
- MUL uses iterative shift-and-add on that same adder.
- Presents a 32-bit result with a start/busy/done handshake to the calculator top level (switch/display logic).

Parameters:
- DATA_W, 16, operand width; must equal the shared adder width.
- RES_W, 32, result width; fixed at 2*DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- op  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- A  input  16  operand A.
- B  input  16  operand B.
- busy  output  1  high while an operation executes.
- done  output  1  one-cycle pulse when Q is valid.
- err  output  1  reserved-opcode flag (see Optional Feature).
- Q  output  32  result, registered, held until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE; Q=0, busy=0, done=0, err=0; internal operand, accumulator and counter registers cleared. Asserting rst mid-operation aborts it immediately; no done pulse follows.
- States: IDLE, EXEC, DONE.
- Start acceptance:
  - IDLE or DONE with start=1: capture A, B and op; clear accumulator; counter=0; next state EXEC; busy=1 from the next cycle.
  - Edge 0 = the edge that samples the accepted start.
- start while busy=1: ignored; no effect on registers.
- ADD: one EXEC cycle.
  - Adder carry-in=0.
  - Q[15:0]=sum, Q[16]=carry-out, Q[31:17]=0.
  - State DONE at edge 2.
- SUB: one EXEC cycle, computing A + ~B with carry-in=1.
  - Q[15:0]=(A-B) mod 2^16.
  - Q[16]=borrow=~carry-out (1 iff A<B).
  - Q[31:17]=0.
  - State DONE at edge 2.
- MUL (unsigned, right-shift scheme): 16 EXEC cycles; counter runs 0..15.
  - Each cycle: the adder sums P[31:16] with (P[0] ? A : 0), carry-in=0.
  - P <= {carry, sum, P[15:1]}.
  - P[15:0] is loaded with B at accept.
  - Q <= P after the 16th iteration; state DONE at edge 17.
- DONE: done=1 for exactly that one cycle and busy=0.
  - Returns to IDLE next cycle unless start=1, in which case it goes to EXEC (back-to-back accepted).
- Latency (accept edge to done-high cycle): ADD/SUB 2 edges; MUL 17 edges.
- Timing relative to done:
  - Q updates on the same edge that done rises.
  - Q is stable from then until 2 edges after the next accept.
- Only one adder instance exists; all arithmetic passes through it.
- Q is never updated on ignored starts.

Optional Feature:
- Macro: CALC_SEQ_ERR_EN.
- Defined: op=11 is accepted and spends 1 EXEC cycle.
  - Result: Q=0, err=1 asserted with done (edge 2).
  - err holds until the next accepted start, which clears it.
- Undefined: op=11 decodes as ADD (identical timing and result); err tied to 0.

Decomposition:
- Package calc_pkg holds:
  - Opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_RSV=2'b11.
  - State encoding ST_IDLE, ST_EXEC, ST_DONE.
  - DATA_W and RES_W constants.
  - MUL_ITER=16.
- One sub-module: seq_adder16.
  - 16-bit ripple-carry adder built from the existing FullAdder cells.
  - Ports: a[15:0], b[15:0], cin, sum[15:0], cout.
  - Instantiated once in calc_op_sequencer.

Test Plan:
- ADD A=0xFFFF, B=0x0001 -> Q=0x0001_0000; done pulses 2 edges after accept; busy high exactly 1 cycle.
- SUB A=0x0005, B=0x0007 -> Q=0x0001_FFFE (borrow=1); SUB A=0x0007, B=0x0005 -> Q=0x0000_0002.
- MUL A=0xFFFF, B=0xFFFF -> Q=0xFFFE_0001 at edge 17; MUL A=0x1234, B=0x0000 -> Q=0; busy high 16 cycles; done one cycle.
- Start with MUL 3*4, then pulse start with ADD 1+1 at edge 5 -> second start ignored; Q=0x0000_000C at edge 17. Then start issued in the DONE cycle -> accepted back-to-back.
- rst asserted mid-MUL (edge 8), asynchronously between edges -> Q=0, busy=0, done=0 immediately; no later done. Then ADD 2+3 -> Q=5.
- op=11, A=1, B=2: with CALC_SEQ_ERR_EN -> Q=0, err=1 with done at edge 2, cleared on next accept. Without the macro -> Q=3, err=0.
